// File: rtl/step_clk_gen_pkg.sv
// ============================================================================
// Module   : step_clk_pkg
// Purpose  : Shared types and constants for the single-step clock generator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package step_clk_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned RUN_DIV_DEF         = 50_000_000;
    localparam int unsigned STEP_CNT_W          = 16;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_e;

endpackage

`default_nettype wire

// File: rtl/step_clk_gen_if.sv
// ============================================================================
// Module   : step_clk_gen_if
// Purpose  : Button/switch inputs and CPU-clock outputs of step_clk_gen.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface step_clk_gen_if;
    import step_clk_pkg::*;

    logic                  oclk;
    logic                  run_mode;
    logic                  rclk;
    logic                  step_pulse;
    logic [STEP_CNT_W-1:0] step_count;
    logic                  btn_db;

    modport master (
        output oclk,
        output run_mode,
        input  rclk,
        input  step_pulse,
        input  step_count,
        input  btn_db
    );

    modport slave (
        input  oclk,
        input  run_mode,
        output rclk,
        output step_pulse,
        output step_count,
        output btn_db
    );

endinterface

`default_nettype wire

// File: rtl/step_clk_gen_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-flop synchronizer plus four-state debounce FSM for one button.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import step_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic db_o,
    output logic db_d_o
);

    localparam int unsigned   CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             btn_s;

    assign btn_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // Any sample disagreeing with the pending level abandons the window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        case (state_q)
            STABLE_LO: begin
                if (btn_s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!btn_s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!btn_s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (btn_s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
    end

    assign db_o   = db_q;
    assign db_d_o = db_d;

endmodule

`default_nettype wire

// File: rtl/step_clk_gen.sv
// ============================================================================
// Module   : step_clk_gen
// Purpose  : CPU clock from a debounced push-button or a free-running divider.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module step_clk_gen
    import step_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned RUN_DIV         = RUN_DIV_DEF
) (
    input  logic          clk_100MHz,
    input  logic          rst,
    step_clk_gen_if.slave bus
);

    localparam int unsigned      DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [1:0]            run_sync_q;
    logic                  mode_q, mode_d;
    logic                  arm_q, arm_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  rclk_q, rclk_d;
    logic                  step_pulse_q;
    logic [STEP_CNT_W-1:0] step_count_q;
    logic                  btn_db_q;
    logic                  btn_db_d;
    logic                  rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk_100MHz),
        .rst_n  (rst),
        .btn_i  (bus.oclk),
        .db_o   (btn_db_q),
        .db_d_o (btn_db_d)
    );

    // Manual mode drives rclk from the debouncer's next state so the CPU
    // edge lands on the same clock edge as btn_db itself.
    always_comb begin
        mode_d = mode_q;
        arm_d  = arm_q;
        div_d  = div_q;
        rclk_d = rclk_q;
        if (!rclk_q && (run_sync_q[1] != mode_q)) begin
            mode_d = run_sync_q[1];
            div_d  = '0;
            rclk_d = 1'b0;
            if (!run_sync_q[1]) begin
                arm_d = !btn_db_q;
            end
        end else if (mode_q) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                rclk_d = !rclk_q;
            end else begin
                div_d  = div_q + DIV_ONE;
            end
        end else if (arm_q) begin
            rclk_d = btn_db_d;
        end else begin
            rclk_d = 1'b0;
            arm_d  = !btn_db_q;
        end
    end

    assign rise = rclk_d & ~rclk_q;

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            run_sync_q   <= 2'b00;
            mode_q       <= 1'b0;
            arm_q        <= 1'b1;
            div_q        <= '0;
            rclk_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            step_count_q <= '0;
        end else begin
            run_sync_q   <= {run_sync_q[0], bus.run_mode};
            mode_q       <= mode_d;
            arm_q        <= arm_d;
            div_q        <= div_d;
            rclk_q       <= rclk_d;
            step_pulse_q <= rise;
            if (rise) begin
                step_count_q <= step_count_q + STEP_CNT_W'(1);
            end
        end
    end

    assign bus.rclk       = rclk_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.step_count = step_count_q;
    assign bus.btn_db     = btn_db_q;

endmodule

`default_nettype wire

// File: tb/tb_step_clk_gen.sv
// ============================================================================
// Module   : tb_step_clk_gen
// Purpose  : Scoreboard bench for step_clk_gen (DEBOUNCE_CYCLES=8, RUN_DIV=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_step_clk_gen;
    import step_clk_pkg::*;

    localparam int DB   = 8;
    localparam int RDIV = 4;
    localparam int BTN_LAT = DB + 2;   // sampling edge to btn_db/rclk change
    localparam int RUN_LAT = 2 + RDIV; // sampling edge to first run-mode rise

    logic clk = 1'b0;
    logic rst_n;

    step_clk_gen_if bus ();

    step_clk_gen #(
        .DEBOUNCE_CYCLES (DB),
        .RUN_DIV         (RDIV)
    ) dut (
        .clk_100MHz (clk),
        .rst        (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [STEP_CNT_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // n counts clock edges starting with the first one after the call,
    // which is the edge that samples a stimulus driven on the prior negedge.
    task automatic wait_for(input string tag, input bit use_btn, input logic lvl,
                            input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if ((use_btn ? bus.btn_db : bus.rclk) === lvl) begin
                n = i;
                break;
            end
        end
        if (n < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.step_pulse === 1'b1) begin
            if (exp_q.size() == 0)
                chk("pulse_unexpected", {31'd0, bus.step_pulse}, 32'd0);
            else
                chk("pulse_count", 32'(bus.step_count), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int hi_cnt;

        rst_n        = 1'b0;
        bus.oclk     = 1'b0;
        bus.run_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rclk",   32'(bus.rclk),       32'd0);
        chk("rst_pulse",  32'(bus.step_pulse), 32'd0);
        chk("rst_count",  32'(bus.step_count), 32'd0);
        chk("rst_btn_db", 32'(bus.btn_db),     32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Clean press and release
        exp_q.push_back(16'd1);
        @(negedge clk) bus.oclk = 1'b1;
        wait_for("press_rise", 1'b0, 1'b1, 40, n);
        chk("press_rise", 32'(n - 1), 32'(BTN_LAT));
        chk("press_btn_db", 32'(bus.btn_db), 32'd1);
        chk("press_pulse", 32'(bus.step_pulse), 32'd1);
        repeat (9) @(posedge clk);
        #1;
        chk("press_count", 32'(bus.step_count), 32'd1);
        @(negedge clk) bus.oclk = 1'b0;
        wait_for("release_fall", 1'b0, 1'b0, 40, n);
        chk("release_fall", 32'(n - 1), 32'(BTN_LAT));
        chk("release_btn_db", 32'(bus.btn_db), 32'd0);
        repeat (3) @(posedge clk);

        // Bounce restarts the window
        exp_q.push_back(16'd2);
        @(negedge clk) bus.oclk = 1'b1;
        repeat (5) @(negedge clk);
        bus.oclk = 1'b0;
        @(negedge clk) bus.oclk = 1'b1;
        wait_for("bounce_rise", 1'b0, 1'b1, 40, n);
        chk("bounce_rise", 32'(n - 1), 32'(BTN_LAT));
        @(negedge clk) bus.oclk = 1'b0;
        wait_for("bounce_fall", 1'b0, 1'b0, 40, n);
        repeat (3) @(posedge clk);

        // Free-run: five rises within 40 cycles of takeover
        for (int k = 3; k <= 7; k++) exp_q.push_back(16'(k));
        @(negedge clk) bus.run_mode = 1'b1;
        wait_for("run_first_rise", 1'b0, 1'b1, 40, n);
        chk("run_first_rise", 32'(n - 1), 32'(RUN_LAT));
        repeat (36) @(posedge clk);
        #1;
        chk("run_40_count", 32'(bus.step_count), 32'd7);
        chk("run_40_rclk",  32'(bus.rclk),       32'd0);

        // Button tracked but ignored in run mode; switch to manual while high
        exp_q.push_back(16'd8);
        exp_q.push_back(16'd9);
        @(negedge clk) bus.oclk = 1'b1;
        wait_for("run_btn_db", 1'b1, 1'b1, 40, n);
        chk("run_btn_db", 32'(n - 1), 32'(BTN_LAT));
        chk("run_btn_rclk", 32'(bus.rclk), 32'd0);
        wait_for("run_rise", 1'b0, 1'b1, 40, n);
        chk("run_rise", 32'(n), 32'd1);
        @(negedge clk) bus.run_mode = 1'b0;
        wait_for("switch_high_phase", 1'b0, 1'b0, 40, n);
        chk("switch_high_phase", 32'(n), 32'(RDIV));
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.rclk !== 1'b0) hi_cnt++;
        end
        chk("held_no_rise", 32'(hi_cnt), 32'd0);
        chk("held_btn_db", 32'(bus.btn_db), 32'd1);
        @(negedge clk) bus.oclk = 1'b0;
        wait_for("held_release", 1'b1, 1'b0, 40, n);
        chk("held_release", 32'(n - 1), 32'(BTN_LAT));
        chk("held_release_rclk", 32'(bus.rclk), 32'd0);
        repeat (3) @(posedge clk);
        exp_q.push_back(16'd10);
        @(negedge clk) bus.oclk = 1'b1;
        wait_for("rearm_rise", 1'b0, 1'b1, 40, n);
        chk("rearm_rise", 32'(n - 1), 32'(BTN_LAT));
        @(negedge clk) bus.oclk = 1'b0;
        wait_for("rearm_fall", 1'b0, 1'b0, 40, n);
        repeat (3) @(posedge clk);

        // Wrap: preload the counter just below the top
        @(negedge clk) force dut.step_count_q = 16'hFFFE;
        @(negedge clk) release dut.step_count_q;
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        @(negedge clk) bus.run_mode = 1'b1;
        wait_for("wrap_first_rise", 1'b0, 1'b1, 40, n);
        chk("wrap_first_rise", 32'(n - 1), 32'(RUN_LAT));
        wait_for("run_high_half", 1'b0, 1'b0, 40, n);
        chk("run_high_half", 32'(n), 32'(RDIV));
        wait_for("run_low_half", 1'b0, 1'b1, 40, n);
        chk("run_low_half", 32'(n), 32'(RDIV));
        chk("wrap_pulse", 32'(bus.step_pulse), 32'd1);
        chk("wrap_count", 32'(bus.step_count), 32'd0);

        // Asynchronous reset while rclk is high in run mode
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_run_rclk",  32'(bus.rclk),       32'd0);
        chk("arst_run_count", 32'(bus.step_count), 32'd0);
        chk("arst_run_pulse", 32'(bus.step_pulse), 32'd0);
        bus.run_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Asynchronous reset mid-debounce, button still held through release
        @(negedge clk) bus.oclk = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_db_btn_db", 32'(bus.btn_db), 32'd0);
        repeat (2) @(posedge clk);
        exp_q.push_back(16'd1);
        @(negedge clk) rst_n = 1'b1;
        wait_for("post_rst_rise", 1'b0, 1'b1, 40, n);
        chk("post_rst_rise", 32'(n - 1), 32'(BTN_LAT));
        @(negedge clk) bus.oclk = 1'b0;
        wait_for("post_rst_fall", 1'b0, 1'b0, 40, n);
        chk("post_rst_fall", 32'(n - 1), 32'(BTN_LAT));
        repeat (3) @(posedge clk);
        #1;

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/step_clk_gen.md
# step_clk_gen

Single-step clock generator for the board top. Sits directly upstream of the CPU core: it turns the raw `oclk` push-button into a clean CPU clock `rclk`, and offers a free-running mode for unattended execution. It also produces a one-cycle step strobe and a step counter for the LED/debug selector.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): required stable time of the synchronized button before a level change is accepted; must be ≥ 2.
- `RUN_DIV`, default 50_000_000: half-period of `rclk` in run mode, in `clk_100MHz` cycles; must be ≥ 1.
- `clk_100MHz`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset, asynchronous, active-low.
- `oclk`  in  1  raw push-button, asynchronous to the clock and bouncing.
- `run_mode`  in  1  raw slide switch: 1 selects free-run, 0 selects manual step.
- `rclk`  out  1  registered, glitch-free CPU clock level.
- `step_pulse`  out  1  one-cycle strobe in the cycle `rclk` rises.
- `step_count`  out  16  number of `rclk` rising edges since reset; wraps.
- `btn_db`  out  1  debounced button level, for display.

## Operation
- `oclk` and `run_mode` each pass through a 2-flop synchronizer. Both synchronizers reset to 0.
- The button debounce FSM has four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO → WAIT_HI when the synced input is 1. The counter loads 1.
  - In WAIT_HI, each cycle the synced input is 1 increments the counter. A cycle at 0 returns the FSM to STABLE_LO and clears the counter.
  - WAIT_HI → STABLE_HI when the counter reaches `DEBOUNCE_CYCLES` while the input is still 1. `btn_db` is set to 1 on the same edge.
  - STABLE_HI, WAIT_LO and the fall of `btn_db` behave symmetrically.
- `run_mode` is synchronized only, not debounced.
- Manual mode: `rclk` follows `btn_db`.
- Run mode:
  - A divider counts 0 … `RUN_DIV`−1.
  - On the terminal count, `rclk` toggles and the divider wraps to 0.
  - The button is ignored for `rclk`, but the debouncer keeps tracking it.
- Mode switching:
  - A change of synced `run_mode` takes effect only while `rclk` is 0. If `rclk` is 1, the old source keeps driving it until it falls, then the new source takes over.
  - Entering run mode clears the divider, so the first rise comes `RUN_DIV` cycles after takeover.
  - Entering manual mode with `btn_db` = 1 keeps `rclk` at 0 until `btn_db` has been seen at 0 (arm flag). A held button never produces a spurious edge.
- `step_pulse` = 1 exactly in the cycle after the edge where `rclk` goes 0 → 1. On that same edge `step_count` increments, wrapping 0xFFFF → 0x0000.

## Timing
- Reset (`rst` = 0, asynchronous) forces:
  - `rclk` = 0, `step_pulse` = 0, `step_count` = 0, `btn_db` = 0
  - FSM = STABLE_LO, divider = 0, arm = 1, synchronizers = 0
- Reset released mid-debounce or mid-run: operation restarts from these values.
- Button latency: `oclk` held high from the clock edge that first samples it → `btn_db` = 1 exactly `DEBOUNCE_CYCLES` + 2 cycles later. `rclk` rises in the same cycle in manual mode. `step_pulse` and the count update occur in that cycle too.
- A bounce (input low for even one synced cycle) restarts the full `DEBOUNCE_CYCLES` window.
- Run mode: `rclk` period is 2·`RUN_DIV` cycles with a 50 % duty cycle.
- All outputs come straight from flops; there is no combinational path from any input to any output.

## Structure
- Package `step_clk_pkg` holds:
  - the debounce state enum
  - default values of `DEBOUNCE_CYCLES` and `RUN_DIV`
  - `STEP_CNT_W` = 16
- Sub-module `btn_debounce` contains the synchronizer, the FSM and the counter, parameterized by `DEBOUNCE_CYCLES`. It is instantiated once, for `oclk`.
- The top of `step_clk_gen` holds the mode mux, the arm flag, the divider, edge detect and `step_count`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 8 and `RUN_DIV` = 4.
- Clean press: `oclk` 0 → 1 held 20 cycles → `btn_db`/`rclk` rise 10 cycles after first sample, one `step_pulse`, `step_count` = 1. Release → `rclk` falls 10 cycles later, no pulse.
- Bounce: `oclk` high 5 cycles, low 1, high 20 → rise occurs 10 cycles after the last 0 → 1, not earlier. `step_count` = 1.
- Run mode: `run_mode` = 1 with button idle → `rclk` toggles every 4 cycles. After 40 cycles from takeover, `step_count` = 5.
- Switch to manual while `rclk` = 1 → `rclk` completes its high phase, then stays 0. Button held at switch → no rise until released and pressed again.
- Wrap: preload via 65 535 run-mode edges → next edge gives `step_count` = 0 and `step_pulse` = 1.
- Reset: assert `rst` = 0 mid-WAIT_HI and mid-run-high → all outputs 0 immediately, without waiting for a clock edge. After release, a press behaves as in the first scenario.
